// File: rtl/conf_int_mul_sched_pkg.sv
// Shared types and constants for the multiplier scheduler.
// s1_entry_t is sized for the widest supported datapath; instances use the low bits.
package conf_int_mul_sched_pkg;

  localparam int unsigned DEF_N_REQ = 4;
  localparam int unsigned MAX_DW    = 64;
  localparam int unsigned MAX_ID_W  = 4;

  function automatic int unsigned id_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [MAX_DW-1:0]   a;
    logic [MAX_DW-1:0]   b;
    logic [MAX_ID_W-1:0] id;
  } s1_entry_t;

endpackage

// File: rtl/conf_int_mul__noFF__arch_agnos.sv
// Combinational unsigned multiplier: operands masked to OP_BITWIDTH, product
// truncated to DATA_PATH_BITWIDTH.
module conf_int_mul__noFF__arch_agnos #(
  parameter int unsigned OP_BITWIDTH        = 16,
  parameter int unsigned DATA_PATH_BITWIDTH = 16
) (
  input  logic [DATA_PATH_BITWIDTH-1:0] a_i,
  input  logic [DATA_PATH_BITWIDTH-1:0] b_i,
  output logic [DATA_PATH_BITWIDTH-1:0] d_o
);

  localparam int unsigned DW = DATA_PATH_BITWIDTH;
  localparam logic [DW-1:0] OP_MASK =
    (OP_BITWIDTH >= DW) ? '1 : DW'((64'd1 << OP_BITWIDTH) - 64'd1);

  assign d_o = (a_i & OP_MASK) * (b_i & OP_MASK);

endmodule

// File: rtl/conf_int_mul_sched_rr_arb.sv
// Combinational N_REQ-way grant: round-robin from ptr_i, or fixed lowest-index
// priority when CONF_INT_MUL_SCHED_FIXED_PRIO_EN is defined (ptr_i then absent).
module conf_int_mul_sched_rr_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
`ifndef CONF_INT_MUL_SCHED_FIXED_PRIO_EN
  input  logic [ID_W-1:0]  ptr_i,
`endif
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o
);

  logic found;

  // First pass covers indices at/after the pointer, second pass wraps to 0.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
`ifndef CONF_INT_MUL_SCHED_FIXED_PRIO_EN
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req_i[i] && (ID_W'(i) >= ptr_i)) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = ID_W'(i);
      end
    end
`endif
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req_i[i]) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/conf_int_mul_sched.sv
// Shares one combinational multiplier among N_REQ requesters via a 2-stage pipe.
// Define CONF_INT_MUL_SCHED_FIXED_PRIO_EN for fixed lowest-index priority.
module conf_int_mul_sched
  import conf_int_mul_sched_pkg::*;
#(
  parameter int unsigned  OP_BITWIDTH        = 16,
  parameter int unsigned  DATA_PATH_BITWIDTH = 16,
  parameter int unsigned  N_REQ              = DEF_N_REQ,
  localparam int unsigned ID_W               = id_w(N_REQ)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_REQ-1:0]                    req_valid,
  output logic [N_REQ-1:0]                    req_ready,
  input  logic [N_REQ*DATA_PATH_BITWIDTH-1:0] req_a,
  input  logic [N_REQ*DATA_PATH_BITWIDTH-1:0] req_b,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [DATA_PATH_BITWIDTH-1:0]       res_d,
  output logic [ID_W-1:0]                     res_id,
  output logic                                busy
);

  localparam int unsigned DW = DATA_PATH_BITWIDTH;
  localparam logic [DW-1:0] OP_MASK =
    (OP_BITWIDTH >= DW) ? '1 : DW'((64'd1 << OP_BITWIDTH) - 64'd1);

  s1_entry_t       s1_q, s1_d;
  logic            s1_v_q, s1_v_d;
  logic            res_v_q, res_v_d;
  logic [DW-1:0]   res_d_q, res_d_d;
  logic [ID_W-1:0] res_id_q, res_id_d;

  logic             s2_load, s1_adv, s1_free, accept;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic [DW-1:0]    a_sel, b_sel, mul_d;
  logic             unused_s1_hi;

  assign s2_load = !res_v_q || res_ready;
  assign s1_adv  = s1_v_q && s2_load;
  assign s1_free = !s1_v_q || s2_load;
  assign accept  = |gnt;

`ifndef CONF_INT_MUL_SCHED_FIXED_PRIO_EN
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  conf_int_mul_sched_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i (req_valid & {N_REQ{s1_free && !rst}}),
`ifndef CONF_INT_MUL_SCHED_FIXED_PRIO_EN
    .ptr_i (rr_ptr_q),
`endif
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        a_sel = req_a[i*DW +: DW];
        b_sel = req_b[i*DW +: DW];
      end
    end
  end

  conf_int_mul__noFF__arch_agnos #(
    .OP_BITWIDTH        (OP_BITWIDTH),
    .DATA_PATH_BITWIDTH (DW)
  ) u_mul (
    .a_i (s1_q.a[DW-1:0]),
    .b_i (s1_q.b[DW-1:0]),
    .d_o (mul_d)
  );

  always_comb begin
    s1_d   = s1_q;
    s1_v_d = s1_v_q;
    if (accept) begin
      s1_v_d  = 1'b1;
      s1_d.a  = MAX_DW'(a_sel & OP_MASK);
      s1_d.b  = MAX_DW'(b_sel & OP_MASK);
      s1_d.id = MAX_ID_W'(gnt_idx);
    end else if (s1_adv) begin
      s1_v_d = 1'b0;
    end

    res_v_d  = res_v_q;
    res_d_d  = res_d_q;
    res_id_d = res_id_q;
    if (s2_load) begin
      res_v_d  = s1_v_q;
      res_d_d  = mul_d;
      res_id_d = s1_q.id[ID_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s1_v_q   <= 1'b0;
      res_v_q  <= 1'b0;
      res_d_q  <= '0;
      res_id_q <= '0;
    end else begin
      s1_q     <= s1_d;
      s1_v_q   <= s1_v_d;
      res_v_q  <= res_v_d;
      res_d_q  <= res_d_d;
      res_id_q <= res_id_d;
    end
  end

  // Entry fields above the configured widths are always zero.
  assign unused_s1_hi = ^{s1_q.a >> DW, s1_q.b >> DW, s1_q.id >> ID_W};

  assign req_ready = gnt;
  assign res_valid = res_v_q;
  assign res_d     = res_d_q;
  assign res_id    = res_id_q;
  assign busy      = s1_v_q | res_v_q;

endmodule

// File: tb/tb_conf_int_mul_sched.sv
// Self-checking bench for conf_int_mul_sched (default and OP_BITWIDTH=8 instances).
module tb_conf_int_mul_sched;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*DW-1:0] req_a, req_b;
  logic            res_valid, res_ready, busy;
  logic [DW-1:0]   res_d;
  logic [IW-1:0]   res_id;

  logic [N-1:0]    v8, rdy8;
  logic [N*DW-1:0] a8, b8;
  logic            rv8, busy8;
  logic [DW-1:0]   rd8;
  logic [IW-1:0]   rid8;

  always #5 clk = ~clk;

  conf_int_mul_sched #(
    .OP_BITWIDTH        (16),
    .DATA_PATH_BITWIDTH (DW),
    .N_REQ              (N)
  ) u_dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready),
    .req_a (req_a), .req_b (req_b),
    .res_valid (res_valid), .res_ready (res_ready),
    .res_d (res_d), .res_id (res_id), .busy (busy)
  );

  conf_int_mul_sched #(
    .OP_BITWIDTH        (8),
    .DATA_PATH_BITWIDTH (DW),
    .N_REQ              (N)
  ) u_dut8 (
    .clk (clk), .rst (rst),
    .req_valid (v8), .req_ready (rdy8),
    .req_a (a8), .req_b (b8),
    .res_valid (rv8), .res_ready (1'b1),
    .res_d (rd8), .res_id (rid8), .busy (busy8)
  );

  int checks = 0;
  int errors = 0;

  // Requester side: pending flag and operands per lane
  logic [N-1:0]  pend;
  logic [DW-1:0] opa [N];
  logic [DW-1:0] opb [N];

  // Reference: stage occupancy, rotation pointer, ordered expected results
  bit m_s1v, m_s2v;
  int m_ptr;
  typedef struct { int id; logic [DW-1:0] d; } res_t;
  res_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] prod(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input int op);
    longint unsigned ma, mb;
    ma = longint'(a) % (64'd1 << op);
    mb = longint'(b) % (64'd1 << op);
    return DW'((ma * mb) % (64'd1 << DW));
  endfunction

  function automatic int exp_grant(input logic [N-1:0] v, input int ptr);
    int start;
    start = ptr;
`ifdef CONF_INT_MUL_SCHED_FIXED_PRIO_EN
    start = 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle();
    int g;
    bit s2_load, s1_free;
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW] = opa[i];
      req_b[i*DW +: DW] = opb[i];
    end
    req_valid = pend;
    @(negedge clk);
    s2_load = !m_s2v || res_ready;
    s1_free = !m_s1v || s2_load;
    g = (rst || !s1_free) ? -1 : exp_grant(pend, m_ptr);
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("res_valid", 32'(res_valid), 32'(m_s2v));
    chk("busy", 32'(busy), 32'(m_s1v || m_s2v));
    if (m_s2v && exp_q.size() > 0) begin
      chk("res_d", 32'(res_d), 32'(exp_q[0].d));
      chk("res_id", 32'(res_id), 32'(exp_q[0].id));
      if (res_ready) void'(exp_q.pop_front());
    end
    if (rst) begin
      m_s1v = 0; m_s2v = 0; m_ptr = 0;
      exp_q.delete();
    end else begin
      if (s2_load) m_s2v = m_s1v;
      if (g >= 0) begin
        m_s1v = 1;
        exp_q.push_back('{g, prod(opa[g], opb[g], 16)});
        pend[g] = 1'b0;
        m_ptr = (g + 1) % N;
      end else if (s2_load) begin
        m_s1v = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input int chance);
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && ($urandom_range(0, 99) < chance)) begin
        opa[i]  = DW'($urandom);
        opb[i]  = DW'($urandom);
        pend[i] = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; res_ready = 1'b1; pend = '1;
    v8 = '0; a8 = '0; b8 = '0;
    for (int i = 0; i < N; i++) begin opa[i] = DW'(i + 1); opb[i] = DW'(i + 3); end
    req_valid = pend; req_a = '0; req_b = '0;
    m_s1v = 0; m_s2v = 0; m_ptr = 0;
    @(posedge clk); #1;

    // Reset held with every requester valid
    cycle(); cycle();
    rst = 1'b0;

    // All lanes continuously valid: rotation 0,1,2,3,0,...
    for (int c = 0; c < 12; c++) begin refill(100); cycle(); end
    pend = '0;
    repeat (3) cycle();

    // Single request from lane 2
    pend[2] = 1'b1; opa[2] = 16'd7; opb[2] = 16'd9;
    cycle(); cycle();
    chk("single_valid", 32'(res_valid), 32'd1);
    chk("single_d", 32'(res_d), 32'd63);
    chk("single_id", 32'(res_id), 32'd2);
    cycle();

    // Full-width wrap: 0xFFFF * 0xFFFF truncates to 1
    pend[1] = 1'b1; opa[1] = 16'hFFFF; opb[1] = 16'hFFFF;
    cycle(); cycle();
    chk("wrap_d", 32'(res_d), 32'h0001);
    cycle();

    // OP_BITWIDTH=8 instance: 0x01FF masks to 0xFF, times 3
    a8[DW-1:0] = 16'h01FF; b8[DW-1:0] = 16'h0003; v8 = 4'b0001;
    #1;
    chk("mask_ready", 32'(rdy8), 32'd1);
    cycle();
    v8 = '0;
    cycle();
    chk("mask_valid", 32'(rv8), 32'd1);
    chk("mask_d", 32'(rd8), 32'h02FD);
    chk("mask_id", 32'(rid8), 32'd0);
    cycle();

    // Backpressure: fill, stall 6 cycles, release and drain
    refill(100); cycle(); refill(100); cycle();
    res_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin refill(100); cycle(); end
    res_ready = 1'b1; pend = '0;
    repeat (4) cycle();

    // Random traffic and consumer stalls
    for (int c = 0; c < 300; c++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      refill(50);
      cycle();
    end
    res_ready = 1'b1; pend = '0;
    repeat (4) cycle();

    // Reset with both stages occupied
    pend = '1; res_ready = 1'b0;
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; pend = '1; res_ready = 1'b1;
    req_valid = pend;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'd1);
    chk("post_rst_res_valid", 32'(res_valid), 32'd0);
    repeat (6) cycle();
    pend = '0;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
